register_auslese: RTL and testbench

Sequential read-out engine for the 64 × 32 processor register file. On a `Start` pulse it drives one read-address port of the register file, walking indices 0..ANZAHL-1. Each returned word goes onto a valid/ready output stream tagged with its index, at up to one word per cycle. It is used by the debug/trace path to dump the architectural register state. It is purely a reader and never writes the register file.

---
 rtl/register_auslese.sv | 111 +++++++++++
 tb/tb_register_auslese.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_auslese.sv
`default_nettype none
// register_auslese: walks register-file indices 0..ANZAHL-1 and streams each word
// with its index over a valid/ready interface. Rev 1.0
module register_auslese #(
  parameter int ANZAHL = 64,
  parameter int ADR    = 6,
  parameter int BREITE = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abbruch,
  output logic [ADR-1:0]    LeseRegister,
  input  logic [BREITE-1:0] LeseDaten,
  output logic [BREITE-1:0] Daten,
  output logic [ADR-1:0]    Index,
  output logic              Gueltig,
  input  logic              Bereit,
  output logic              Letztes,
  output logic              Beschaeftigt,
  output logic              Fertig
);

  localparam logic [ADR:0] ENDE    = (ADR+1)'(ANZAHL);
  localparam logic [ADR:0] LETZTER = ENDE - (ADR+1)'(1);

  typedef enum logic {
    IDLE   = 1'b0,
    LAUFEN = 1'b1
  } zustand_t;

  zustand_t          zustand, zustand_n;
  logic [ADR:0]      zeiger, zeiger_n;
  logic [BREITE-1:0] daten_n;
  logic [ADR-1:0]    index_n;
  logic              gueltig_n, letztes_n, fertig_n, beschaeftigt_n;

  // The read address comes straight from the counter flop so the register file
  // sees it a full cycle before the capturing edge.
  assign LeseRegister = zeiger[ADR-1:0];

  always_comb begin
    zustand_n = zustand;
    zeiger_n  = zeiger;
    daten_n   = Daten;
    index_n   = Index;
    gueltig_n = Gueltig;
    letztes_n = Letztes;
    fertig_n  = 1'b0;
    case (zustand)
      IDLE: begin
        if (Start && !Abbruch) begin
          zeiger_n  = '0;
          zustand_n = LAUFEN;
        end
      end
      LAUFEN: begin
        if (Abbruch) begin
          gueltig_n = 1'b0;
          letztes_n = 1'b0;
          zeiger_n  = '0;
          zustand_n = IDLE;
        end else if ((zeiger < ENDE) && (!Gueltig || Bereit)) begin
          daten_n   = LeseDaten;
          index_n   = zeiger[ADR-1:0];
          letztes_n = (zeiger == LETZTER);
          gueltig_n = 1'b1;
          zeiger_n  = zeiger + (ADR+1)'(1);
        end else if (Gueltig && Bereit) begin
          // Counter exhausted and the final word was just taken.
          gueltig_n = 1'b0;
          letztes_n = 1'b0;
          fertig_n  = 1'b1;
          zeiger_n  = '0;
          zustand_n = IDLE;
        end
      end
      default: begin
        zustand_n = IDLE;
        zeiger_n  = '0;
        gueltig_n = 1'b0;
        letztes_n = 1'b0;
      end
    endcase
    beschaeftigt_n = (zustand_n == LAUFEN);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand      <= IDLE;
      zeiger       <= '0;
      Daten        <= '0;
      Index        <= '0;
      Gueltig      <= 1'b0;
      Letztes      <= 1'b0;
      Beschaeftigt <= 1'b0;
      Fertig       <= 1'b0;
    end else begin
      zustand      <= zustand_n;
      zeiger       <= zeiger_n;
      Daten        <= daten_n;
      Index        <= index_n;
      Gueltig      <= gueltig_n;
      Letztes      <= letztes_n;
      Beschaeftigt <= beschaeftigt_n;
      Fertig       <= fertig_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_auslese.sv
`default_nettype none
// tb_register_auslese: randomized scoreboard bench for register_auslese.
module tb_register_auslese;
  localparam int ANZAHL = 64;
  localparam int ADR    = 6;
  localparam int BREITE = 32;

  logic              Clock = 1'b0;
  logic              Reset, Start, Abbruch, Bereit;
  logic [ADR-1:0]    LeseRegister, Index;
  logic [BREITE-1:0] LeseDaten, Daten;
  logic              Gueltig, Letztes, Beschaeftigt, Fertig;

  logic [BREITE-1:0] regs [ANZAHL];
  logic [BREITE-1:0] model [ANZAHL];
  logic              preload, we;
  logic [ADR-1:0]    wa;
  logic [BREITE-1:0] wd;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int fertig_seen = 0;
  int bereit_mode = 0;
  int pat = 0;

  typedef struct {
    int                idx;
    logic [BREITE-1:0] d;
    logic              last;
  } exp_t;
  exp_t sb[$];

  register_auslese #(.ANZAHL(ANZAHL), .ADR(ADR), .BREITE(BREITE)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Abbruch(Abbruch),
    .LeseRegister(LeseRegister), .LeseDaten(LeseDaten),
    .Daten(Daten), .Index(Index), .Gueltig(Gueltig), .Bereit(Bereit),
    .Letztes(Letztes), .Beschaeftigt(Beschaeftigt), .Fertig(Fertig)
  );

  always #5 Clock = ~Clock;

  assign LeseDaten = regs[LeseRegister];

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (preload) begin
      for (int i = 0; i < ANZAHL; i++)
        regs[i] <= (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected stream for one complete dump: every index in order, data as the
  // register file will hold it at capture time.
  task automatic push_dump();
    exp_t e;
    for (int i = 0; i < ANZAHL; i++) begin
      e.idx  = i;
      e.d    = model[i];
      e.last = (i == ANZAHL - 1);
      sb.push_back(e);
    end
  endtask

  // Consumer ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random, 3 = held low
  initial begin
    Bereit = 1'b1;
    forever begin
      @(posedge Clock);
      #1;
      case (bereit_mode)
        0: Bereit = 1'b1;
        1: begin Bereit = ((pat % 4) == 0) || ((pat % 4) == 3); pat++; end
        2: Bereit = 1'($urandom_range(0, 1));
        default: Bereit = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each accepted word, checks stall stability.
  initial begin
    logic              prev_stall;
    logic [BREITE-1:0] prev_d;
    logic [ADR-1:0]    prev_i;
    logic              prev_l, prev_f;
    exp_t              e;
    prev_stall = 1'b0; prev_f = 1'b0;
    prev_d = '0; prev_i = '0; prev_l = 1'b0;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        if (prev_stall) begin
          chk("stall_valid", 64'(Gueltig), 64'(1));
          chk("stall_data", 64'(Daten), 64'(prev_d));
          chk("stall_index", 64'(Index), 64'(prev_i));
          chk("stall_last", 64'(Letztes), 64'(prev_l));
        end
        if (Gueltig && Bereit && !Abbruch) begin
          if (sb.size() == 0) begin
            chk("unexpected_word", 64'(Index), 64'hFFFF);
          end else begin
            e = sb.pop_front();
            chk("word_index", 64'(Index), 64'(e.idx));
            chk("word_data", 64'(Daten), 64'(e.d));
            chk("word_last", 64'(Letztes), 64'(e.last));
          end
        end
        if (Fertig) fertig_seen++;
        if (Fertig && prev_f) chk("fertig_pulse_width", 64'(2), 64'(1));
      end
      prev_stall = !Reset && Gueltig && !Bereit && !Abbruch;
      prev_d = Daten; prev_i = Index; prev_l = Letztes; prev_f = Fertig;
    end
  end

  task automatic wait_word(input int idx, input int budget);
    int n;
    n = 0;
    while (!(Gueltig && Index == ADR'(idx)) && n < budget) begin
      @(posedge Clock); #2;
      n++;
    end
    if (n >= budget) chk("timeout_word", 64'(n), 64'(0));
  endtask

  task automatic wait_fertig(input int budget);
    int n;
    n = 0;
    while (!Fertig && n < budget) begin
      @(posedge Clock); #2;
      n++;
    end
    if (n >= budget) chk("timeout_fertig", 64'(n), 64'(0));
  endtask

  task automatic start_dump();
    Start = 1'b1;
    push_dump();
    @(posedge Clock); #2;
    Start = 1'b0;
  endtask

  initial begin
    int f0;
    Reset = 1'b1; Start = 1'b0; Abbruch = 1'b0;
    preload = 1'b1; we = 1'b0; wa = '0; wd = '0;
    for (int i = 0; i < ANZAHL; i++)
      model[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
    repeat (3) @(posedge Clock);
    #2;
    preload = 1'b0;
    Reset = 1'b0;
    chk("rst_lese_register", 64'(LeseRegister), 64'(0));
    chk("rst_daten", 64'(Daten), 64'(0));
    chk("rst_index", 64'(Index), 64'(0));
    chk("rst_gueltig", 64'(Gueltig), 64'(0));
    chk("rst_letztes", 64'(Letztes), 64'(0));
    chk("rst_beschaeftigt", 64'(Beschaeftigt), 64'(0));
    chk("rst_fertig", 64'(Fertig), 64'(0));

    // Full dump with Bereit high, Start sampled at edge 10
    bereit_mode = 0;
    while (cyc < 9) begin @(posedge Clock); #2; end
    Start = 1'b1;
    push_dump();
    @(posedge Clock); #2;
    Start = 1'b0;
    chk("start_edge", 64'(cyc), 64'(10));
    chk("busy_after_start", 64'(Beschaeftigt), 64'(1));
    chk("no_valid_yet", 64'(Gueltig), 64'(0));
    @(posedge Clock); #2;
    chk("first_valid", 64'(Gueltig), 64'(1));
    chk("first_index", 64'(Index), 64'(0));
    wait_word(ANZAHL - 1, 200);
    chk("last_word_edge", 64'(cyc), 64'(74));
    Start = 1'b1;  // coincides with the final handshake, must be ignored
    @(posedge Clock); #2;
    Start = 1'b0;
    chk("fertig_edge", 64'(cyc), 64'(75));
    chk("fertig_high", 64'(Fertig), 64'(1));
    chk("idle_after_dump", 64'(Beschaeftigt), 64'(0));
    chk("valid_low_after_dump", 64'(Gueltig), 64'(0));
    @(posedge Clock); #2;
    chk("fertig_dropped", 64'(Fertig), 64'(0));
    chk("final_start_ignored", 64'(Beschaeftigt), 64'(0));
    chk("sb_empty_full", 64'(sb.size()), 64'(0));

    // Backpressure 1,0,0,1 with a Start pulse mid-dump that must be ignored
    bereit_mode = 1; pat = 0;
    f0 = fertig_seen;
    start_dump();
    wait_word(30, 400);
    Start = 1'b1;
    @(posedge Clock); #2;
    Start = 1'b0;
    wait_fertig(600);
    @(posedge Clock); #2;
    chk("sb_empty_backpressure", 64'(sb.size()), 64'(0));
    chk("fertig_once_backpressure", 64'(fertig_seen - f0), 64'(1));

    // Abort while Index 20 is presented and accepted
    bereit_mode = 0;
    f0 = fertig_seen;
    start_dump();
    wait_word(20, 200);
    Abbruch = 1'b1;
    @(posedge Clock); #2;
    Abbruch = 1'b0;
    chk("abort_valid", 64'(Gueltig), 64'(0));
    chk("abort_busy", 64'(Beschaeftigt), 64'(0));
    chk("abort_remaining", 64'(sb.size()), 64'(ANZAHL - 20));
    sb.delete();
    repeat (3) @(posedge Clock);
    #2;
    chk("abort_no_fertig", 64'(fertig_seen - f0), 64'(0));
    bereit_mode = 2;
    start_dump();
    wait_fertig(600);
    @(posedge Clock); #2;
    chk("sb_empty_restart", 64'(sb.size()), 64'(0));

    // Reset mid-dump at Index 33 with Bereit low; Start held during Reset
    f0 = fertig_seen;
    bereit_mode = 2;
    start_dump();
    wait_word(33, 600);
    bereit_mode = 3; Bereit = 1'b0;
    Reset = 1'b1; Start = 1'b1;
    @(posedge Clock); #2;
    chk("mid_rst_lese_register", 64'(LeseRegister), 64'(0));
    chk("mid_rst_daten", 64'(Daten), 64'(0));
    chk("mid_rst_index", 64'(Index), 64'(0));
    chk("mid_rst_gueltig", 64'(Gueltig), 64'(0));
    chk("mid_rst_letztes", 64'(Letztes), 64'(0));
    chk("mid_rst_busy", 64'(Beschaeftigt), 64'(0));
    chk("mid_rst_fertig", 64'(Fertig), 64'(0));
    @(posedge Clock); #2;
    Reset = 1'b0; Start = 1'b0;
    sb.delete();
    @(posedge Clock); #2;
    chk("rst_start_ignored", 64'(Beschaeftigt), 64'(0));
    chk("rst_no_fertig", 64'(fertig_seen - f0), 64'(0));

    // Start together with Abbruch in IDLE stays idle
    Start = 1'b1; Abbruch = 1'b1;
    @(posedge Clock); #2;
    Start = 1'b0; Abbruch = 1'b0;
    chk("start_abort_idle", 64'(Beschaeftigt), 64'(0));
    @(posedge Clock); #2;
    chk("start_abort_no_valid", 64'(Gueltig), 64'(0));

    // Write r5 on the edge that captures Index 3; word 5 must see it
    bereit_mode = 0;
    model[5] = 32'hDEAD_BEEF;
    start_dump();
    wait_word(2, 200);
    we = 1'b1; wa = 6'd5; wd = 32'hDEAD_BEEF;
    @(posedge Clock); #2;
    we = 1'b0;
    chk("write_edge_index", 64'(Index), 64'(3));
    wait_fertig(200);
    @(posedge Clock); #2;
    chk("sb_empty_write", 64'(sb.size()), 64'(0));
    chk("fertig_total", 64'(fertig_seen), 64'(4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
